// File: rtl/uart_rx.sv
// UART receiver with an AHB-lite slave port: start/8 data/XOR parity/stop frames,
// four good bytes packed little-endian into a word, words queued in a small FIFO.
module uart_rx #(
    parameter int          BPS_115200    = 434,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] ADDR_RECVDATA = 32'h0000_0000,
    parameter logic [31:0] ADDR_STATUS   = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel_rx,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        uartRx_int_clear,
    input  logic        RX,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic        irq_uartRx
);
    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [8:0]    SAMPLE_PT  = 9'(BPS_115200 / 2);
    localparam logic [8:0]    LAST_CNT   = 9'(BPS_115200 - 1);
    localparam logic [1:0]    NONSEQ     = 2'b10;
    localparam logic [1:0]    RESP_OKAY  = 2'b00;
    localparam logic [1:0]    RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync_prev;
    logic [1:0]    r_warm;
    logic [8:0]    r_bps_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity_bad;
    logic [1:0]    r_byte_cnt;
    logic [31:0]   r_word;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          r_overrun;
    logic          r_frame_err;
    logic          r_parity_err;
    logic          r_irq;
    logic          r_wr_status;
    logic [31:0]   r_hrdata;
    logic          r_hready;
    logic [1:0]    r_hresp;

    logic          w_fall;
    logic          w_sample;
    logic          w_wrap;
    logic          w_stop_eval;
    logic          w_set_frame;
    logic          w_set_parity;
    logic          w_push_req;
    logic [31:0]   w_push_word;
    logic          w_empty;
    logic          w_full;
    logic          w_access;
    logic          w_pop;
    logic          w_push_ok;
    logic [31:0]   w_status;
    logic          w_unused;

    // The sync flops come out of reset high, so their first cycles are not real
    // line data; edges are only trusted once the warm-up count saturates.
    assign w_fall       = (r_warm == 2'd3) && r_sync_prev && !r_sync2;
    assign w_sample     = (r_bps_cnt == SAMPLE_PT);
    assign w_wrap       = (r_bps_cnt == LAST_CNT);
    assign w_stop_eval  = (r_state == ST_STOP) && w_sample;
    assign w_set_frame  = w_stop_eval && !r_sync2;
    assign w_set_parity = w_stop_eval && r_sync2 && r_parity_bad;
    assign w_push_req   = w_stop_eval && r_sync2 && !r_parity_bad && (r_byte_cnt == 2'd3);
    assign w_push_word  = {r_shift, r_word[23:0]};

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_access  = hsel_rx && (HTRANS == NONSEQ);
    assign w_pop     = w_access && !HWRITE && (HADDR == ADDR_RECVDATA) && !w_empty;
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_status  = {24'b0, 3'(r_count), r_overrun, r_frame_err, r_parity_err, w_full, !w_empty};
    assign w_unused  = ^{HSIZE, HWDATA[31:5], HWDATA[1:0]};

    assign HRDATA     = r_hrdata;
    assign HREADY     = r_hready;
    assign HRESP      = r_hresp;
    assign irq_uartRx = r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
            r_warm      <= 2'd0;
        end else begin
            r_sync1     <= RX;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            if (r_warm != 2'd3)
                r_warm <= r_warm + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bps_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity_bad <= 1'b0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
        end else begin
            if (r_state == ST_IDLE || w_wrap)
                r_bps_cnt <= '0;
            else
                r_bps_cnt <= r_bps_cnt + 9'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_sample && r_sync2)
                        r_state <= ST_IDLE;
                    else if (w_wrap)
                        r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_sample)
                        r_shift <= {r_sync2, r_shift[7:1]};
                    if (w_wrap) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (w_sample)
                        r_parity_bad <= (r_sync2 != ^r_shift);
                    if (w_wrap)
                        r_state <= ST_STOP;
                end
                ST_STOP: begin
                    // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
                    if (w_sample) begin
                        r_state <= ST_IDLE;
                        if (!r_sync2 || r_parity_bad) begin
                            r_byte_cnt <= '0;
                        end else begin
                            r_word[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= w_push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags and interrupt: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (r_wr_status) begin
                if (HWDATA[4]) r_overrun    <= 1'b0;
                if (HWDATA[3]) r_frame_err  <= 1'b0;
                if (HWDATA[2]) r_parity_err <= 1'b0;
            end
            if (w_push_req && w_full && !w_pop) r_overrun <= 1'b1;
            if (w_set_frame)                    r_frame_err  <= 1'b1;
            if (w_set_parity)                   r_parity_err <= 1'b1;
            if (uartRx_int_clear)               r_irq <= 1'b0;
            if (w_push_ok)                      r_irq <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hrdata    <= '0;
            r_hready    <= 1'b1;
            r_hresp     <= RESP_OKAY;
            r_wr_status <= 1'b0;
        end else begin
            r_hrdata    <= '0;
            r_hready    <= 1'b1;
            r_hresp     <= RESP_OKAY;
            r_wr_status <= w_access && HWRITE && (HADDR == ADDR_STATUS);
            if (w_access && !HWRITE) begin
                if (HADDR == ADDR_RECVDATA) begin
                    if (!w_empty)
                        r_hrdata <= r_mem[r_rd_ptr];
                end else if (HADDR == ADDR_STATUS) begin
                    r_hrdata <= w_status;
                end
            end
            if (w_access && HWRITE && (HADDR == ADDR_RECVDATA)) begin
                r_hready <= 1'b0;
                r_hresp  <= RESP_ERROR;
            end
        end
    end

endmodule
